// File: rtl/match_session_ctrl_if.sv
// Signal bundle between the session controller, the configuration logic,
// the pattern comparator and the timeout timer.
interface match_session_ctrl_if;
  logic       Config_Enable;
  logic       Pattern_Valid;
  logic       Pattern_Match;
  logic       Timer_TimeOut;
  logic       Timer_Load;
  logic       Timer_Enable;
  logic       Session_Active;
  logic       Match_Found;
  logic       Session_TimeOut;
  logic       Locked;
  logic [3:0] Attempts_Left;

  // Driver side: configuration, comparator and timer feeding the controller.
  modport master (
    output Config_Enable, Pattern_Valid, Pattern_Match, Timer_TimeOut,
    input  Timer_Load, Timer_Enable, Session_Active, Match_Found,
           Session_TimeOut, Locked, Attempts_Left
  );

  modport slave (
    input  Config_Enable, Pattern_Valid, Pattern_Match, Timer_TimeOut,
    output Timer_Load, Timer_Enable, Session_Active, Match_Found,
           Session_TimeOut, Locked, Attempts_Left
  );
endinterface

// File: rtl/match_session_ctrl.sv
// Sequences one pattern-matching session around the shared timeout timer:
// arm on a Config_Enable rise, run until match/timeout/exhaustion/abort, lock out.
module match_session_ctrl #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int LOCK_W         = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  match_session_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    RUN     = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0]        ATTEMPTS_INIT = 4'(MAX_ATTEMPTS);
  localparam logic [LOCK_W-1:0] LOCK_LAST     = LOCK_W'(LOCKOUT_CYCLES - 1);

  state_t            state_q, state_n;
  logic              cfg_q;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_n;
  logic [3:0]        left_q, left_n;
  logic              match_n, tout_n;
  logic              load_q, enable_q, active_q, match_q, tout_q, locked_q;
  logic              cfg_rise;

  assign cfg_rise = bus.Config_Enable && !cfg_q;

  // NOTE: every variable gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state_q;
    left_n     = left_q;
    lock_cnt_n = lock_cnt_q;
    match_n    = 1'b0;
    tout_n     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_rise) begin
          state_n = ARM;
          left_n  = ATTEMPTS_INIT;
        end
      end
      ARM: state_n = bus.Config_Enable ? RUN : IDLE;
      RUN: begin
        // Abort beats match beats timeout beats mismatch.
        if (!bus.Config_Enable) begin
          state_n = IDLE;
        end else if (bus.Pattern_Valid && bus.Pattern_Match) begin
          state_n = IDLE;
          match_n = 1'b1;
        end else if (bus.Timer_TimeOut) begin
          state_n = LOCKOUT;
          tout_n  = 1'b1;
        end else if (bus.Pattern_Valid) begin
          if (left_q != 4'd0) left_n = left_q - 4'd1;
          if (left_q <= 4'd1) state_n = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_n    = IDLE;
          lock_cnt_n = '0;
        end else begin
          lock_cnt_n = lock_cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they describe.
  // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      cfg_q      <= 1'b0;
      lock_cnt_q <= '0;
      left_q     <= ATTEMPTS_INIT;
      load_q     <= 1'b0;
      enable_q   <= 1'b0;
      active_q   <= 1'b0;
      match_q    <= 1'b0;
      tout_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cfg_q      <= bus.Config_Enable;
      lock_cnt_q <= lock_cnt_n;
      left_q     <= left_n;
      load_q     <= (state_n == ARM);
      enable_q   <= (state_n == RUN);
      active_q   <= (state_n == ARM) || (state_n == RUN);
      match_q    <= match_n;
      tout_q     <= tout_n;
      locked_q   <= (state_n == LOCKOUT);
    end
  end

  assign bus.Timer_Load      = load_q;
  assign bus.Timer_Enable    = enable_q;
  assign bus.Session_Active  = active_q;
  assign bus.Match_Found     = match_q;
  assign bus.Session_TimeOut = tout_q;
  assign bus.Locked          = locked_q;
  assign bus.Attempts_Left   = left_q;

endmodule

// File: doc/match_session_ctrl.md
Name: match_session_ctrl

Overview:
Sequences one pattern-matching session around the shared timeout timer. A rising edge on Config_Enable arms the session: the timer is loaded, then enabled, and the session counts failed pattern attempts. The session ends on a match, a timeout, exhausted attempts, or a Config_Enable abort. Timeout and exhausted attempts both enter a fixed lockout period. Sits between the configuration logic, the pattern comparator and the timer module.

Parameters:
MAX_ATTEMPTS, 3, mismatches allowed per session (1..15).
LOCKOUT_CYCLES, 8, clock cycles Locked stays high (>=1).
LOCK_W, 16, lockout counter width (must hold LOCKOUT_CYCLES).

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-low reset.
Config_Enable  input  1  session request; rising edge arms, low aborts.
Pattern_Valid  input  1  one-cycle strobe: comparator result ready.
Pattern_Match  input  1  comparator result, qualified by Pattern_Valid.
Timer_TimeOut  input  1  timer expiry flag from the timer.
Timer_Load  output  1  one-cycle pulse: timer reloads its timeout value.
Timer_Enable  output  1  timer counts while high.
Session_Active  output  1  high in ARM and RUN.
Match_Found  output  1  one-cycle pulse on a successful match.
Session_TimeOut  output  1  one-cycle pulse on timer expiry.
Locked  output  1  high during LOCKOUT.
Attempts_Left  output  4  remaining attempts in the current session.

Behaviour:
- Reset (Rst=0, async): state IDLE, all 1-bit outputs 0, Attempts_Left=MAX_ATTEMPTS, lockout counter 0, edge-detect register 0.
- All outputs are registered. Pulses are high for exactly the one cycle after the edge that sampled the event.
- Config edge detect: Cfg_q <= Config_Enable every cycle. A rise is Config_Enable=1 && Cfg_q=0.
- IDLE:
  - A rise moves to ARM and reloads Attempts_Left=MAX_ATTEMPTS.
  - A held-high Config_Enable never re-arms.
  - Pattern_Valid is ignored.
- ARM (exactly 1 cycle): Timer_Load=1, Timer_Enable=0, Session_Active=1.
  - Next state is RUN.
  - If Config_Enable=0 in this cycle, next state is IDLE instead.
- RUN: Timer_Enable=1, Session_Active=1. Events are evaluated each cycle in this priority order:
  1. Config_Enable=0: go to IDLE. No pulses, Attempts_Left unchanged.
  2. Pattern_Valid && Pattern_Match: go to IDLE, Match_Found=1 for 1 cycle.
  3. Timer_TimeOut=1: go to LOCKOUT, Session_TimeOut=1 for 1 cycle. Attempts_Left is not decremented, even if a mismatch is sampled in the same cycle.
  4. Pattern_Valid && !Pattern_Match:
     - Attempts_Left decrements.
     - If it was 1 it becomes 0 and the state goes to LOCKOUT; otherwise the state stays in RUN.
- Latency: a rise sampled at edge k gives Timer_Load in cycle k+1 and Timer_Enable from cycle k+2.
- LOCKOUT: Locked=1, Timer_Enable=0, Session_Active=0.
  - Counter runs 0..LOCKOUT_CYCLES-1, so Locked is high exactly LOCKOUT_CYCLES cycles; then state goes to IDLE and the counter clears.
  - Config_Enable and Pattern_Valid are ignored.
  - Leaving lockout with Config_Enable still high does not re-arm; a fresh rise is required.
- Timer_Enable deasserts on the edge that leaves RUN. The timer must never see Timer_Load and Timer_Enable high together.
- Attempts_Left holds its value outside RUN until the next ARM reload. It never underflows below 0.
- Rst asserted in any state: immediate return to reset values. Pending pulses are dropped.

Test Plan:
1. Rise Config_Enable, match on 2nd RUN cycle:
   - Timer_Load high 1 cycle, then Timer_Enable high 2 cycles.
   - Match_Found single pulse, back to IDLE, Attempts_Left=3.
2. Three mismatches (Pattern_Valid=1, Pattern_Match=0):
   - Attempts_Left steps 3->2->1->0.
   - Locked high exactly 8 cycles, then IDLE.
   - Config_Enable held high does not re-arm until it toggles low then high.
3. Timer_TimeOut=1 in RUN, same cycle as a mismatch with Attempts_Left=2:
   - Session_TimeOut pulse, LOCKOUT entered, Attempts_Left stays 2.
4. Match and Timer_TimeOut in the same cycle -> Match_Found pulse only, IDLE, Locked stays 0.
5. Drop Config_Enable mid-RUN after 1 mismatch -> IDLE, no pulses, Attempts_Left=2; the next rise reloads it to 3.
6. Assert Rst=0 mid-LOCKOUT (counter=4), asynchronously between clock edges:
   - Locked and all outputs go to 0 immediately, Attempts_Left=3.
   - After release, a new rise arms normally.
